// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the single-cycle CPU subset: instruction kinds,
// opcode/func values and instruction field bit positions.
package sc_isa_pkg;

  // Symbolic instruction kinds; codes 20-31 are illegal.
  typedef enum logic [4:0] {
    KindAdd  = 5'd0,
    KindSub  = 5'd1,
    KindAnd  = 5'd2,
    KindOr   = 5'd3,
    KindXor  = 5'd4,
    KindSll  = 5'd5,
    KindSrl  = 5'd6,
    KindSra  = 5'd7,
    KindJr   = 5'd8,
    KindAddi = 5'd9,
    KindAndi = 5'd10,
    KindOri  = 5'd11,
    KindXori = 5'd12,
    KindLw   = 5'd13,
    KindSw   = 5'd14,
    KindBeq  = 5'd15,
    KindBne  = 5'd16,
    KindLui  = 5'd17,
    KindJ    = 5'd18,
    KindJal  = 5'd19
  } kind_e;

  // Word layouts; each selects which descriptor fields reach the word.
  typedef enum logic [2:0] {
    FmtRArith,
    FmtRShift,
    FmtRJump,
    FmtI,
    FmtILui,
    FmtJ,
    FmtIllegal
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } enc_state_e;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpAddi    = 6'b001000;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpXori    = 6'b001110;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;

  localparam logic [5:0] FuncAdd = 6'b100000;
  localparam logic [5:0] FuncSub = 6'b100010;
  localparam logic [5:0] FuncAnd = 6'b100100;
  localparam logic [5:0] FuncOr  = 6'b100101;
  localparam logic [5:0] FuncXor = 6'b100110;
  localparam logic [5:0] FuncSll = 6'b000000;
  localparam logic [5:0] FuncSrl = 6'b000010;
  localparam logic [5:0] FuncSra = 6'b000011;
  localparam logic [5:0] FuncJr  = 6'b001000;

  localparam int unsigned OpMsb     = 31;
  localparam int unsigned OpLsb     = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned RdMsb     = 15;
  localparam int unsigned RdLsb     = 11;
  localparam int unsigned SaMsb     = 10;
  localparam int unsigned SaLsb     = 6;
  localparam int unsigned FuncMsb   = 5;
  localparam int unsigned FuncLsb   = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;

endpackage

// File: rtl/sc_inst_pack.sv
// Combinational packer: instruction kind plus descriptor fields -> 32-bit MIPS word.
// Fields not used by the selected layout never reach the word.
module sc_inst_pack
  import sc_isa_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  fmt_e       fmt;
  logic [5:0] op;
  logic [5:0] func;

  // Decode the kind into a layout plus its opcode/func constants.
  always_comb begin
    fmt  = FmtIllegal;
    op   = OpSpecial;
    func = 6'b000000;
    unique case (kind)
      KindAdd:  begin fmt = FmtRArith; func = FuncAdd; end
      KindSub:  begin fmt = FmtRArith; func = FuncSub; end
      KindAnd:  begin fmt = FmtRArith; func = FuncAnd; end
      KindOr:   begin fmt = FmtRArith; func = FuncOr;  end
      KindXor:  begin fmt = FmtRArith; func = FuncXor; end
      KindSll:  begin fmt = FmtRShift; func = FuncSll; end
      KindSrl:  begin fmt = FmtRShift; func = FuncSrl; end
      KindSra:  begin fmt = FmtRShift; func = FuncSra; end
      KindJr:   begin fmt = FmtRJump;  func = FuncJr;  end
      KindAddi: begin fmt = FmtI;      op = OpAddi;    end
      KindAndi: begin fmt = FmtI;      op = OpAndi;    end
      KindOri:  begin fmt = FmtI;      op = OpOri;     end
      KindXori: begin fmt = FmtI;      op = OpXori;    end
      KindLw:   begin fmt = FmtI;      op = OpLw;      end
      KindSw:   begin fmt = FmtI;      op = OpSw;      end
      KindBeq:  begin fmt = FmtI;      op = OpBeq;     end
      KindBne:  begin fmt = FmtI;      op = OpBne;     end
      KindLui:  begin fmt = FmtILui;   op = OpLui;     end
      KindJ:    begin fmt = FmtJ;      op = OpJ;       end
      KindJal:  begin fmt = FmtJ;      op = OpJal;     end
      default:  fmt = FmtIllegal;
    endcase
  end

  // Assemble the word from the fields the layout uses; illegal kinds emit a nop.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    unique case (fmt)
      FmtRArith: begin
        word[OpMsb:OpLsb]     = OpSpecial;
        word[RsMsb:RsLsb]     = rs;
        word[RtMsb:RtLsb]     = rt;
        word[RdMsb:RdLsb]     = rd;
        word[FuncMsb:FuncLsb] = func;
      end
      FmtRShift: begin
        word[OpMsb:OpLsb]     = OpSpecial;
        word[RtMsb:RtLsb]     = rt;
        word[RdMsb:RdLsb]     = rd;
        word[SaMsb:SaLsb]     = sa;
        word[FuncMsb:FuncLsb] = func;
      end
      FmtRJump: begin
        word[OpMsb:OpLsb]     = OpSpecial;
        word[RsMsb:RsLsb]     = rs;
        word[FuncMsb:FuncLsb] = func;
      end
      FmtI: begin
        word[OpMsb:OpLsb]   = op;
        word[RsMsb:RsLsb]   = rs;
        word[RtMsb:RtLsb]   = rt;
        word[ImmMsb:ImmLsb] = imm;
      end
      FmtILui: begin
        word[OpMsb:OpLsb]   = op;
        word[RtMsb:RtLsb]   = rt;
        word[ImmMsb:ImmLsb] = imm;
      end
      FmtJ: begin
        word[OpMsb:OpLsb]         = op;
        word[TargetMsb:TargetLsb] = target;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sc_inst_encoder.sv
// Instruction-image loader: accepts symbolic descriptors, encodes them through one
// registered stage and streams the words to sequential instruction-memory addresses.
module sc_inst_encoder
  import sc_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_wrap
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              word_last_q, word_last_d;  // word in the output stage ends the session
  logic              last_taken_q, last_taken_d;  // no more descriptors this session
  logic              err_ill_q, err_ill_d;
  logic              err_wrap_q, err_wrap_d;
  logic              ready_c;
  logic              fire;
  logic [31:0]       pack_word;
  logic              pack_illegal;

  sc_inst_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .sa      (in_sa),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign fire = out_valid_q & out_ready;

  // Session FSM, output stage refill and address/flag updates.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    word_d       = word_q;
    addr_d       = addr_q;
    word_last_d  = word_last_q;
    last_taken_d = last_taken_q;
    err_ill_d    = err_ill_q;
    err_wrap_d   = err_wrap_q;
    ready_c      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          addr_d       = BaseAddr;
          last_taken_d = 1'b0;
          err_ill_d    = 1'b0;
          err_wrap_d   = 1'b0;
        end
      end
      StRun: begin
        // The stage can refill in the same cycle it drains.
        ready_c = !last_taken_q && (!out_valid_q || out_ready);
        if (fire) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          if (addr_q == '1) err_wrap_d = 1'b1;
          if (word_last_q) state_d = StDone;
        end
        if (in_valid && ready_c) begin
          out_valid_d  = 1'b1;
          word_d       = pack_word;
          word_last_d  = in_last;
          last_taken_d = in_last;
          if (pack_illegal) err_ill_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      word_q       <= 32'h0000_0000;
      addr_q       <= BaseAddr;
      word_last_q  <= 1'b0;
      last_taken_q <= 1'b0;
      err_ill_q    <= 1'b0;
      err_wrap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      word_last_q  <= word_last_d;
      last_taken_q <= last_taken_d;
      err_ill_q    <= err_ill_d;
      err_wrap_q   <= err_wrap_d;
    end
  end

  assign in_ready    = ready_c;
  assign out_valid   = out_valid_q;
  assign out_word    = word_q;
  assign out_addr    = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err_illegal = err_ill_q;
  assign err_wrap    = err_wrap_q;

endmodule

// File: tb/tb_sc_inst_encoder.sv
// Bench for sc_inst_encoder: directed table sessions, randomized sessions against an
// encoding/stream model, and a mid-stream reset. Two instances run in lockstep, one
// with BASE_ADDR=0 and one with BASE_ADDR=0xFE to exercise address wrap.
module tb_sc_inst_encoder;

  localparam logic [7:0] Base0 = 8'h00;
  localparam logic [7:0] Base1 = 8'hFE;

  typedef struct packed {
    logic [4:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
    logic        has_exp;
    logic [31:0] exp;
  } desc_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, in_valid, in_last, out_ready;
  logic [4:0]  in_kind, in_rs, in_rt, in_rd, in_sa;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready0, out_valid0, busy0, done0, ill0, wrap0;
  logic [7:0]  out_addr0;
  logic [31:0] out_word0;
  logic        in_ready1, out_valid1, busy1, done1, ill1, wrap1;
  logic [7:0]  out_addr1;
  logic [31:0] out_word1;

  always #5 clock = ~clock;

  sc_inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_addr(out_addr0), .out_word(out_word0), .busy(busy0),
    .done(done0), .err_illegal(ill0), .err_wrap(wrap0)
  );

  sc_inst_encoder #(.ADDR_W(8), .BASE_ADDR(32'hFE)) dut1 (
    .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_addr(out_addr1), .out_word(out_word1), .busy(busy1),
    .done(done1), .err_illegal(ill1), .err_wrap(wrap1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  desc_t       send_q[$];
  logic [31:0] exp_q[$];
  bit          exp_last_q[$];
  bit          m_session, m_last_sent, m_done, m_ill, m_wrap0, m_wrap1;
  logic [7:0]  m_addr0, m_addr1;
  bit          prev_stall;
  logic [31:0] prev_word;
  logic [7:0]  prev_addr;
  bit          junk_valid = 1'b0;
  int          gap_pct = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [5:0] func_of(input int k);
    case (k)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b100110;
      5: return 6'b000000;
      6: return 6'b000010;
      7: return 6'b000011;
      default: return 6'b001000;
    endcase
  endfunction

  function automatic logic [5:0] op_of(input int k);
    case (k)
      9:  return 6'b001000;
      10: return 6'b001100;
      11: return 6'b001101;
      12: return 6'b001110;
      13: return 6'b100011;
      14: return 6'b101011;
      15: return 6'b000100;
      16: return 6'b000101;
      18: return 6'b000010;
      default: return 6'b000011;
    endcase
  endfunction

  // Reference encoding: returns {illegal, word}.
  function automatic logic [32:0] ref_model(input desc_t d);
    int k;
    k = int'(d.kind);
    if (k <= 4)  return {1'b0, 6'd0, d.rs, d.rt, d.rd, 5'd0, func_of(k)};
    if (k <= 7)  return {1'b0, 6'd0, 5'd0, d.rt, d.rd, d.sa, func_of(k)};
    if (k == 8)  return {1'b0, 6'd0, d.rs, 15'd0, 6'b001000};
    if (k <= 16) return {1'b0, op_of(k), d.rs, d.rt, d.imm};
    if (k == 17) return {1'b0, 6'b001111, 5'd0, d.rt, d.imm};
    if (k <= 19) return {1'b0, op_of(k), d.target};
    return {1'b1, 32'd0};
  endfunction

  function automatic desc_t mk(input int kind, input int rs, input int rt, input int rd,
                               input int sa, input int imm, input int tgt, input bit last,
                               input logic [31:0] exp);
    desc_t d;
    d.kind = 5'(kind); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.sa = 5'(sa);
    d.imm = 16'(imm); d.target = 26'(tgt); d.last = last; d.has_exp = 1'b1; d.exp = exp;
    return d;
  endfunction

  function automatic desc_t rand_desc(input bit last);
    desc_t d;
    d.kind = 5'($urandom_range(0, 31));
    d.rs = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom); d.sa = 5'($urandom);
    d.imm = 16'($urandom); d.target = 26'($urandom);
    d.last = last; d.has_exp = 1'b0; d.exp = 32'd0;
    return d;
  endfunction

  task automatic drive(input desc_t d, input bit v);
    in_valid = v; in_kind = d.kind; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd;
    in_sa = d.sa; in_imm = d.imm; in_target = d.target; in_last = d.last;
  endtask

  task automatic clear_model();
    send_q.delete(); exp_q.delete(); exp_last_q.delete();
    m_session = 0; m_last_sent = 0; m_done = 0; m_ill = 0; m_wrap0 = 0; m_wrap1 = 0;
    prev_stall = 0;
  endtask

  task automatic reset_checks();
    check("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    check("rst_in_ready", {in_ready1, in_ready0}, 2'b00);
    check("rst_busy", {busy1, busy0}, 2'b00);
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_err_illegal", {ill1, ill0}, 2'b00);
    check("rst_err_wrap", {wrap1, wrap0}, 2'b00);
    check("rst_out_word", {out_word1, out_word0}, 64'd0);
    check("rst_out_addr0", out_addr0, Base0);
    check("rst_out_addr1", out_addr1, Base1);
  endtask

  // One clock cycle: drive, check observed outputs against the model, advance the model.
  task automatic tick(input bit st, input bit rdy);
    bit          exp_ready, fire, next_done, has_word;
    logic [32:0] r;
    desc_t       d;
    start = st;
    out_ready = rdy;
    if (send_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) drive(send_q[0], 1'b1);
    else if (send_q.size() == 0 && junk_valid) drive(rand_desc($urandom_range(0, 1) == 1), 1'b1);
    else in_valid = 1'b0;
    #1;
    has_word  = exp_q.size() != 0;
    exp_ready = m_session && !m_last_sent && (!has_word || rdy);
    fire      = has_word && rdy;
    check("out_valid", {out_valid1, out_valid0}, {2{has_word}});
    check("in_ready", {in_ready1, in_ready0}, {2{exp_ready}});
    check("busy", {busy1, busy0}, {2{m_session || m_done}});
    check("done", {done1, done0}, {2{m_done}});
    check("err_illegal", {ill1, ill0}, {2{m_ill}});
    check("err_wrap0", wrap0, m_wrap0);
    check("err_wrap1", wrap1, m_wrap1);
    if (prev_stall) begin
      check("stall_word_hold", out_word0, prev_word);
      check("stall_addr_hold", out_addr0, prev_addr);
    end
    prev_stall = has_word && !rdy;
    prev_word  = out_word0;
    prev_addr  = out_addr0;
    next_done  = 1'b0;
    if (st && !m_session && !m_done) begin
      m_session = 1; m_last_sent = 0; m_ill = 0; m_wrap0 = 0; m_wrap1 = 0;
      m_addr0 = Base0; m_addr1 = Base1;
    end
    if (fire) begin
      check("out_word0", out_word0, exp_q[0]);
      check("out_word1", out_word1, exp_q[0]);
      check("out_addr0", out_addr0, m_addr0);
      check("out_addr1", out_addr1, m_addr1);
      if (m_addr0 == 8'hFF) m_wrap0 = 1;
      if (m_addr1 == 8'hFF) m_wrap1 = 1;
      m_addr0 = m_addr0 + 8'd1;
      m_addr1 = m_addr1 + 8'd1;
      void'(exp_q.pop_front());
      if (exp_last_q.pop_front()) begin
        m_session = 0;
        next_done = 1;
      end
    end
    if (exp_ready && in_valid && send_q.size() > 0) begin
      d = send_q.pop_front();
      r = ref_model(d);
      exp_q.push_back(d.has_exp ? d.exp : r[31:0]);
      exp_last_q.push_back(d.last);
      if (r[32]) m_ill = 1;
      if (d.last) m_last_sent = 1;
    end
    m_done = next_done;
    @(posedge clock);
    #1;
  endtask

  // mode 0: always ready, 1: random ready, 2: out_ready low for session cycles 3..5.
  task automatic run_session(input int mode, input bit start_on_done, input bit start_mid);
    int k;
    bit rdy;
    tick(1'b1, 1'b1);
    k = 1;
    while ((m_session || m_done) && k < 600) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(k >= 3 && k <= 5);
      endcase
      tick((start_on_done && m_done) || (start_mid && k == 7), rdy);
      k++;
    end
    check("session_completes", {31'd0, m_session || m_done}, 32'd0);
    tick(1'b0, 1'b1);
  endtask

  desc_t tbl[13];

  initial begin
    int sess;
    resetn = 1'b0; start = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1'b0, 32'd0), 1'b0);
    clear_model();
    m_addr0 = Base0; m_addr1 = Base1;
    repeat (2) @(posedge clock);
    #1;
    reset_checks();
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Directed sessions: {kind, rs, rt, rd, sa, imm, target, last, expected word}.
    tbl[0]  = mk(0, 1, 2, 3, 0, 0, 0, 1'b1, 32'h0022_1820);
    tbl[1]  = mk(9, 0, 1, 0, 0, 5, 0, 1'b0, 32'h2001_0005);
    tbl[2]  = mk(13, 1, 2, 0, 0, 4, 0, 1'b0, 32'h8C22_0004);
    tbl[3]  = mk(5, 7, 2, 4, 3, 0, 0, 1'b0, 32'h0002_20C0);
    tbl[4]  = mk(15, 1, 2, 0, 0, 16'hFFFF, 0, 1'b0, 32'h1022_FFFF);
    tbl[5]  = mk(19, 0, 0, 0, 0, 0, 32'h10, 1'b1, 32'h0C00_0010);
    tbl[6]  = mk(25, 3, 4, 5, 6, 16'h1234, 26'h155, 1'b0, 32'h0000_0000);
    tbl[7]  = mk(8, 31, 5, 6, 7, 16'hBEEF, 26'h3FF, 1'b0, 32'h03E0_0008);
    tbl[8]  = mk(17, 3, 4, 9, 9, 16'h1234, 26'h1, 1'b0, 32'h3C04_1234);
    tbl[9]  = mk(0, 1, 2, 3, 9, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0022_1820);
    tbl[10] = mk(18, 7, 7, 7, 7, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0BFF_FFFF);
    tbl[11] = mk(7, 9, 4, 5, 31, 16'hAAAA, 0, 1'b0, 32'h0004_2FC3);
    tbl[12] = mk(14, 29, 31, 1, 1, 16'h8000, 26'h123, 1'b1, 32'hAFBF_8000);
    sess = 0;
    for (int i = 0; i < 13; i++) begin
      send_q.push_back(tbl[i]);
      if (tbl[i].last) begin
        run_session((sess == 1) ? 2 : 0, 1'b0, 1'b0);
        sess++;
      end
    end

    // Randomized sessions with input gaps, backpressure and stray descriptors.
    junk_valid = 1'b1;
    gap_pct = 25;
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 30; n++) send_q.push_back(rand_desc(n == 29));
      run_session(1, s == 1, s == 2);
    end

    // Asynchronous reset in the middle of a stream.
    junk_valid = 1'b0;
    gap_pct = 0;
    for (int n = 0; n < 20; n++) send_q.push_back(rand_desc(n == 19));
    tick(1'b1, 1'b1);
    repeat (6) tick(1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    reset_checks();
    clear_model();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    for (int n = 0; n < 6; n++) send_q.push_back(rand_desc(n == 5));
    run_session(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
